// File: rtl/seq_det_pkg.sv
// Shared types and constants for the sequence-detector core: FSM state encoding
// and default maximal-length tap masks for common LFSR widths.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [3:0]  TAPS_4  = 4'hC;
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [20:0] TAPS_21 = 21'h140000;

endpackage

// File: rtl/seq_detector_gen_lfsr_gen.sv
// Fibonacci LFSR bit source: shift-left register with tap-mask XOR feedback,
// zero-seed substitution and a flag that the next state closes the period.
module lfsr_gen
    import seq_det_pkg::*;
#(
    parameter int                LFSR_W = 21,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(TAPS_21)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [LFSR_W-1:0] seed,
    output logic              msb,
    output logic              period_end
);

    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] start;
    logic [LFSR_W-1:0] lfsr_next;
    logic [LFSR_W-1:0] seed_eff;

    // An all-zero state would lock the register up, so it is never loaded.
    assign seed_eff   = (seed == '0) ? LFSR_W'(1) : seed;
    assign lfsr_next  = {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)};
    assign period_end = (lfsr_next == start);
    assign msb        = lfsr[LFSR_W-1];

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr  <= LFSR_W'(1);
            start <= LFSR_W'(1);
        end else if (load) begin
            lfsr  <= seed_eff;
            start <= seed_eff;
        end else if (advance) begin
            lfsr <= lfsr_next;
        end
    end

endmodule

// File: rtl/seq_detector_gen.sv
// Sequence-detector core: prescaled LFSR stepping, pattern history and fill FSM,
// match/period pulses. Define SEQ_DET_MATCH_CNT_EN to build the match counter.
module seq_detector_gen
    import seq_det_pkg::*;
#(
    parameter int                LFSR_W   = 21,
    parameter logic [LFSR_W-1:0] TAPS     = LFSR_W'(TAPS_21),
    parameter int                PAT_W    = 12,
    parameter int                CNT_W    = 9,
    parameter int                PRESCALE = 2500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    input  logic [PAT_W-1:0]  pattern,
    input  logic              overlap,
    output logic              step,
    output logic              lfsr_msb,
    output logic              seq_detected,
    output logic              max_tick,
    output logic [CNT_W-1:0]  match_count
);

    localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PRE_W-1:0]  pre_cnt;
    logic [PAT_W-1:0]  history;
    logic [PAT_W-1:0]  history_next;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_inc;
    logic              wrap;
    logic              match;
    logic              period_end;
    state_t            state;
    state_t            state_next;

    // wrap is the internal step strobe; the visible step pulse lags it by one edge.
    assign wrap         = en && (pre_cnt == PRE_LAST);
    assign history_next = {history[PAT_W-2:0], lfsr_msb};
    assign fill_inc     = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
    assign match        = (fill_inc == FILL_FULL) && (history_next == pattern);

    lfsr_gen #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS)
    ) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .load       (seed_load),
        .advance    (wrap),
        .seed       (seed),
        .msb        (lfsr_msb),
        .period_end (period_end)
    );

    always_ff @(posedge clk) begin
        if (rst || seed_load) begin
            pre_cnt      <= '0;
            history      <= '0;
            fill         <= '0;
            step         <= 1'b0;
            seq_detected <= 1'b0;
            max_tick     <= 1'b0;
        end else begin
            step         <= wrap;
            seq_detected <= wrap && match;
            max_tick     <= wrap && period_end;
            if (en) begin
                pre_cnt <= wrap ? '0 : pre_cnt + PRE_W'(1);
            end
            if (wrap) begin
                history <= history_next;
                fill    <= (match && !overlap) ? '0 : fill_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || seed_load) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: next-state gets a default before the case so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (en) state_next = FILL;
            FILL: if (wrap && fill_inc == FILL_FULL && !(match && !overlap)) state_next = RUN;
            RUN:  if (wrap && match && !overlap) state_next = FILL;
            default: state_next = IDLE;
        endcase
    end

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || seed_load) begin
            cnt <= '0;
        end else if (wrap && period_end) begin
            cnt <= match ? CNT_W'(1) : '0;
        end else if (wrap && match && cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign match_count = cnt;
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_gen.sv
// Self-checking bench: two 4-bit LFSR configurations compared against a
// behavioural model (step counting, bit-window history) plus directed scenarios.
module tb_seq_detector_gen;

`ifdef SEQ_DET_MATCH_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       seed_load = 1'b0;
    logic [3:0] seed = 4'h0;
    logic       overlap = 1'b1;
    logic [1:0] pattern_a = 2'b11;
    logic [3:0] pattern_b = 4'b1010;

    logic       step_a, msb_a, det_a, tick_a;
    logic [1:0] cnt_a;
    logic       step_b, msb_b, det_b, tick_b;
    logic [8:0] cnt_b;

    int n_vec = 0;
    int n_err = 0;

    // Model state, index 0 = u_a, 1 = u_b
    int m_lfsr[2];
    int m_hist[2];
    int m_fill[2];
    int m_pcnt[2];
    int m_steps[2];
    int m_cnt[2];
    bit m_step[2];
    bit m_det[2];
    bit m_tick[2];

    always #5 clk = ~clk;

    seq_detector_gen #(
        .LFSR_W(4), .TAPS(4'hC), .PAT_W(2), .CNT_W(2), .PRESCALE(1)
    ) u_a (
        .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed(seed),
        .pattern(pattern_a), .overlap(overlap), .step(step_a), .lfsr_msb(msb_a),
        .seq_detected(det_a), .max_tick(tick_a), .match_count(cnt_a)
    );

    seq_detector_gen #(
        .LFSR_W(4), .TAPS(4'hC), .PAT_W(4), .CNT_W(9), .PRESCALE(4)
    ) u_b (
        .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed(seed),
        .pattern(pattern_b), .overlap(overlap), .step(step_b), .lfsr_msb(msb_b),
        .seq_detected(det_b), .max_tick(tick_b), .match_count(cnt_b)
    );

    // Period ticks are derived from the step count since load (period 15), not from state compare.
    task automatic model_edge(input int k);
        int pw, pre, cmax, pat, fb;
        bit match;
        pw   = (k == 0) ? 2 : 4;
        pre  = (k == 0) ? 1 : 4;
        cmax = (k == 0) ? 3 : 511;
        pat  = (k == 0) ? int'(pattern_a) : int'(pattern_b);
        m_step[k] = 1'b0;
        m_det[k]  = 1'b0;
        m_tick[k] = 1'b0;
        if (rst || seed_load) begin
            m_lfsr[k]  = rst ? 1 : ((seed == 4'h0) ? 1 : int'(seed));
            m_hist[k]  = 0;
            m_fill[k]  = 0;
            m_pcnt[k]  = 0;
            m_steps[k] = 0;
            m_cnt[k]   = 0;
        end else if (en) begin
            if (m_pcnt[k] == pre - 1) begin
                m_pcnt[k] = 0;
                m_step[k] = 1'b1;
                m_hist[k] = ((m_hist[k] * 2) + ((m_lfsr[k] / 8) % 2)) % (1 << pw);
                fb = $countones(m_lfsr[k] & 12) % 2;
                m_lfsr[k] = ((m_lfsr[k] * 2) + fb) % 16;
                m_steps[k]++;
                if (m_fill[k] < pw) m_fill[k]++;
                match = (m_fill[k] == pw) && (m_hist[k] == pat);
                if (match) begin
                    m_det[k] = 1'b1;
                    if (!overlap) m_fill[k] = 0;
                end
                m_tick[k] = (m_steps[k] % 15 == 0);
                if (m_tick[k]) m_cnt[k] = match ? 1 : 0;
                else if (match && m_cnt[k] < cmax) m_cnt[k]++;
            end else begin
                m_pcnt[k]++;
            end
        end
    endtask

    function automatic logic [12:0] exp_vec(input int k);
        logic [8:0] c;
        c = CNT_ON ? 9'(m_cnt[k]) : 9'd0;
        return {m_step[k], m_lfsr[k][3], m_det[k], m_tick[k], c};
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; en = 1'b0; seed_load = 1'b0; seed = 4'h0;
        overlap = 1'b1; pattern_a = 2'b11; pattern_b = 4'b1010;
        repeat (3) begin
            cycle();
            n_vec++;
            if ({step_a, msb_a, det_a, tick_a, cnt_a, step_b, msb_b, det_b, tick_b, cnt_b} !== '0) begin
                n_err++;
                $display("FAIL reset_outputs: got a=%b%b%b%b/%0d b=%b%b%b%b/%0d, want all 0",
                         step_a, msb_a, det_a, tick_a, cnt_a, step_b, msb_b, det_b, tick_b, cnt_b);
            end
        end
        rst = 1'b0; en = 1'b1;
        cycle();
        n = 1;
        n_vec++;
        if (step_a !== 1'b1) begin
            n_err++;
            $display("FAIL first_step_a: got %b want 1", step_a);
        end
        while (step_b !== 1'b1 && n < 10) begin
            cycle();
            n++;
        end
        n_vec++;
        if (step_b !== 1'b1 || n != 4) begin
            n_err++;
            $display("FAIL first_step_b: step=%b after %0d cycles, want step=1 after 4", step_b, n);
        end
    endtask

    task automatic test_period_sat();
        int n, dets;
        logic [1:0] pre_cnt;
        seed = 4'h0; seed_load = 1'b1;
        cycle();
        seed_load = 1'b0;
        n_vec++;
        if ({step_a, msb_a, det_a, tick_a, cnt_a} !== 6'b0) begin
            n_err++;
            $display("FAIL seed_zero_load: got %b%b%b%b/%0d want 0000/0", step_a, msb_a, det_a, tick_a, cnt_a);
        end
        n = 0;
        while (tick_a !== 1'b1 && n < 40) begin
            cycle();
            n++;
        end
        n_vec++;
        if (tick_a !== 1'b1 || n != 15) begin
            n_err++;
            $display("FAIL first_tick_a: tick=%b after %0d steps, want tick after 15", tick_a, n);
        end
        dets = 0;
        pre_cnt = 2'd0;
        for (int i = 1; i <= 15; i++) begin
            cycle();
            if (det_a === 1'b1) dets++;
            if (i == 14) pre_cnt = cnt_a;
            if (i < 15 && tick_a === 1'b1) begin
                n_vec++;
                n_err++;
                $display("FAIL early_tick_a: tick after %0d steps, want 15", i);
            end
        end
        n_vec++;
        if (tick_a !== 1'b1) begin
            n_err++;
            $display("FAIL period_tick_a: tick=%b at step 15, want 1", tick_a);
        end
        n_vec++;
        if (dets != 4) begin
            n_err++;
            $display("FAIL overlap_11_count: got %0d matches per period, want 4", dets);
        end
        n_vec++;
        if (pre_cnt !== (CNT_ON ? 2'd3 : 2'd0)) begin
            n_err++;
            $display("FAIL count_saturate: got %0d want %0d", pre_cnt, CNT_ON ? 3 : 0);
        end
        n_vec++;
        if (cnt_a !== (CNT_ON ? {1'b0, det_a} : 2'd0)) begin
            n_err++;
            $display("FAIL count_tick_reload: got %0d want %0d", cnt_a, CNT_ON ? int'(det_a) : 0);
        end
    endtask

    task automatic test_nonoverlap();
        int n, dets;
        overlap = 1'b0;
        n = 0;
        do begin
            cycle();
            n++;
        end while (tick_a !== 1'b1 && n < 40);
        dets = 0;
        for (int i = 1; i <= 15; i++) begin
            cycle();
            if (det_a === 1'b1) dets++;
        end
        n_vec++;
        if (tick_a !== 1'b1 || dets != 3) begin
            n_err++;
            $display("FAIL nonoverlap_11_count: tick=%b matches=%0d, want tick=1 matches=3", tick_a, dets);
        end
        overlap = 1'b1;
    endtask

    task automatic test_overlap_b();
        int n, dets;
        pattern_b = 4'b1010;
        n = 0;
        do begin
            cycle();
            n++;
        end while (tick_b !== 1'b1 && n < 80);
        dets = 0;
        n = 0;
        do begin
            cycle();
            n++;
            if (det_b === 1'b1) dets++;
        end while (tick_b !== 1'b1 && n < 70);
        n_vec++;
        if (n != 60 || dets != 1) begin
            n_err++;
            $display("FAIL pattern_1010_period: %0d cycles %0d matches, want 60 cycles 1 match", n, dets);
        end
    endtask

    task automatic test_en_pause();
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (step_b !== 1'b1 && n < 20);
        cycle();
        cycle();
        en = 1'b0;
        repeat (10) begin
            cycle();
            n_vec++;
            if ({step_b, det_b, tick_b} !== 3'b000) begin
                n_err++;
                $display("FAIL pause_pulses: got step/det/tick=%b%b%b want 000", step_b, det_b, tick_b);
            end
        end
        en = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (step_b !== 1'b1 && n < 10);
        n_vec++;
        if (step_b !== 1'b1 || n != 2) begin
            n_err++;
            $display("FAIL pause_resume: step=%b after %0d cycles, want step=1 after 2", step_b, n);
        end
    endtask

    task automatic test_seed_load();
        int n, steps;
        logic [3:0] s_eff;
        pattern_b = 4'($urandom_range(1, 15));
        for (int pass = 0; pass < 2; pass++) begin
            seed = 4'($urandom);
            s_eff = (seed == 4'h0) ? 4'h1 : seed;
            seed_load = 1'b1;
            cycle();
            seed_load = 1'b0;
            n_vec++;
            if ({step_b, msb_b, det_b, tick_b, cnt_b} !== {1'b0, s_eff[3], 2'b00, 9'd0}) begin
                n_err++;
                $display("FAIL seed_load_state: got %b%b%b%b/%0d want 0%b00/0",
                         step_b, msb_b, det_b, tick_b, cnt_b, s_eff[3]);
            end
            if (pass == 0) begin
                steps = 0;
                n = 0;
                while (steps < 2 && n < 20) begin
                    cycle();
                    n++;
                    if (step_b === 1'b1) steps++;
                end
            end
        end
        steps = 0;
        n = 0;
        while (det_b !== 1'b1 && n < 400) begin
            cycle();
            n++;
            if (step_b === 1'b1) steps++;
        end
        n_vec++;
        if (det_b !== 1'b1 || steps < 4) begin
            n_err++;
            $display("FAIL refill_match: det=%b after %0d steps, want det=1 after at least 4", det_b, steps);
        end
    endtask

    task automatic test_random();
        logic [12:0] obs;
        for (int i = 0; i < 1500; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            seed_load = ($urandom_range(0, 79) == 0);
            en        = ($urandom_range(0, 7) != 0);
            seed      = 4'($urandom);
            if ($urandom_range(0, 49) == 0) overlap = ~overlap;
            if ($urandom_range(0, 29) == 0) pattern_a = 2'($urandom);
            if ($urandom_range(0, 29) == 0) pattern_b = 4'($urandom);
            cycle();
            obs = {step_a, msb_a, det_a, tick_a, 7'd0, cnt_a};
            n_vec++;
            if (obs !== exp_vec(0)) begin
                n_err++;
                $display("FAIL random_a cycle %0d: got %b want %b", i, obs, exp_vec(0));
            end
            obs = {step_b, msb_b, det_b, tick_b, cnt_b};
            n_vec++;
            if (obs !== exp_vec(1)) begin
                n_err++;
                $display("FAIL random_b cycle %0d: got %b want %b", i, obs, exp_vec(1));
            end
        end
        rst = 1'b0;
        seed_load = 1'b0;
        en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_period_sat();
        test_nonoverlap();
        test_overlap_b();
        test_en_pause();
        test_seed_load();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_detector_gen.md
# seq_detector_gen

Parametrised sequence-detector core: a configurable-width Fibonacci LFSR bit source feeding a programmable-pattern detector with overlapping and non-overlapping match modes, a per-period match counter and an LFSR period tick. It replaces the fixed 21-bit LFSR, 12-bit detector and derived-clock top level. Stepping is driven by an internal clock-enable prescaler, so the whole block runs on one clock with no generated clocks. It sits between the board clock/reset and the LED/testbench observers.

## Interface
- LFSR_W, 21, LFSR width (3..32)
- TAPS, 21'h140000, feedback tap mask (bit i set = lfsr[i] in XOR), maximal-length polynomial required
- PAT_W, 12, pattern width (2..LFSR_W)
- CNT_W, 9, match counter width
- PRESCALE, 2500, clk cycles per LFSR step (>=1)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  run enable; low freezes prescaler, LFSR, history and FSM
- seed_load  in  1  synchronous seed load strobe
- seed  in  LFSR_W  seed value; zero is substituted with 1
- pattern  in  PAT_W  target sequence, MSB = oldest bit; sampled every step
- overlap  in  1  1 = overlapping matches, 0 = non-overlapping
- step  out  1  one-cycle pulse, the cycle an LFSR step occurs
- lfsr_msb  out  1  current serial bit, lfsr[LFSR_W-1]
- seq_detected  out  1  one-cycle match pulse
- max_tick  out  1  one-cycle pulse at LFSR period completion
- match_count  out  CNT_W  matches in current period, saturating

## Operation
- Priority per edge: rst > seed_load > en.
- Reset: lfsr = 1, start = 1, history = 0, fill = 0, prescaler = 0, state IDLE; all outputs 0 (lfsr_msb = 0 for LFSR_W >= 2).
- seed_load: lfsr and start <= (seed==0 ? 1 : seed); history, fill, prescaler and match_count cleared; state IDLE; no pulses that cycle.
- Prescaler: counts 0..PRESCALE-1 while en=1. step is a registered pulse, high the cycle after the counter wraps. PRESCALE=1 gives a step every enabled cycle.
- On step (internal strobe):
  - history <= {history[PAT_W-2:0], lfsr_msb}.
  - lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)}.
  - fill <= min(fill+1, PAT_W).
- FSM:
  - IDLE -> FILL on first cycle with en=1.
  - FILL -> RUN when fill reaches PAT_W.
  - RUN -> FILL after a match when overlap=0; fill clears to 0, so PAT_W fresh bits are needed.
  - RUN stays in RUN after a match when overlap=1.
- Match: on a step edge, if the updated fill == PAT_W and the updated history == pattern, seq_detected <= 1 for one cycle.
- Period: on a step edge whose next lfsr == start, max_tick <= 1 for one cycle. Period = 2^LFSR_W - 1 steps.
- match_count:
  - Increments on a match and saturates at all-ones.
  - On a max_tick edge it loads 0, or 1 if a match coincides.
- overlap or pattern changes take effect at the next step; no flush.

## Timing
- step, seq_detected and max_tick are all registered. seq_detected and max_tick are asserted in the same cycle as step (the cycle after the prescaler wrap), never longer than 1 cycle.
- lfsr_msb changes the cycle step is high.
- First possible match: PAT_W steps after leaving IDLE.
- en low mid-prescale holds the count and resumes without loss. Pulses never assert while en=0.
- rst or seed_load coinciding with a step wins; the step is discarded.

## Configuration
- SEQ_DET_MATCH_CNT_EN defined: match counter built as above.
- Not defined: counter logic removed and match_count tied to 0. seq_detected and max_tick are unchanged.

## Structure
- Shared package seq_det_pkg:
  - FSM state enum (IDLE, FILL, RUN).
  - Default tap constants for widths 4, 8, 16 and 21 (4'hC, 8'hB8, 16'hB400, 21'h140000).
- Sub-module lfsr_gen, holding the LFSR register, tap XOR, seed substitution and period compare.
- Prescaler, history, FSM and counter live in the top.

## Test plan
- rst held for 3 cycles: all outputs 0 and lfsr_msb = 0. With PRESCALE=4, the first step is high on the 4th enabled cycle after release.
- LFSR_W=4, TAPS=4'hC, PRESCALE=1, seed 4'h0 -> lfsr loads 1; max_tick exactly every 15 steps; 15 distinct states between ticks.
- LFSR_W=4, PAT_W=4, overlap=1, pattern 4'b1010 -> one seq_detected and match_count = 1 per steady-state period.
- LFSR_W=4, PAT_W=2, pattern 2'b11 -> overlap=1 gives 4 matches per steady period. overlap=0 gives only 2 matches in the "1111" run.
- CNT_W=2, pattern matching more than 3 times per period -> match_count holds 3, then returns to 0 (or 1) at max_tick.
- en dropped for 10 cycles mid-prescale, and a seed_load pulse mid-FILL -> resumes with no lost or extra step; after the load, fill restarts and the first match occurs no earlier than PAT_W steps later.
